// File: rtl/wb_pkg.sv
// Shared types for the writeback stage: result select encoding, the MEM/WB bundle,
// and the result-select helper.
package wb_pkg;

  localparam int WB_DATA_W = 16;
  localparam int WB_REG_AW = 4;

  typedef enum logic [1:0] {
    WB_ALU  = 2'b00,
    WB_LOAD = 2'b01,
    WB_PC   = 2'b10,
    WB_RSVD = 2'b11
  } wb_sel_t;

  typedef struct packed {
    logic                 valid;
    logic                 reg_write;
    logic [WB_REG_AW-1:0] dst;
    wb_sel_t              sel;
    logic [WB_DATA_W-1:0] alu;
    logic [WB_DATA_W-1:0] load;
    logic [WB_DATA_W-1:0] pc2;
    logic                 halt;
  } wb_bundle_t;

  localparam wb_bundle_t WB_BUBBLE = '0;

  // The reserved encoding falls back to the ALU result so a corrupt select still writes something sane.
  function automatic logic [WB_DATA_W-1:0] wb_select(input wb_bundle_t b);
    logic [WB_DATA_W-1:0] r;
    r = b.alu;
    case (b.sel)
      WB_LOAD: r = b.load;
      WB_PC:   r = b.pc2;
      default: r = b.alu;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/wb_pipe_reg.sv
// MEM/WB pipeline register: reset, halt and flush load a bubble, stall holds, otherwise load.
module wb_pipe_reg
  import wb_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       halted,
  input  logic       flush,
  input  logic       stall,
  input  wb_bundle_t d,
  output wb_bundle_t q
);

  // Halt outranks flush, which outranks stall.
  always_ff @(posedge clk) begin
    if (rst) begin
      q <= WB_BUBBLE;
    end else if (halted || flush) begin
      q <= WB_BUBBLE;
    end else if (!stall) begin
      q <= d;
    end
  end

endmodule

// File: rtl/regfile_writeback.sv
// Writeback stage: MEM/WB register, result select, register-file write qualify,
// sticky halted flag and saturating retired-instruction counter.
module regfile_writeback
  import wb_pkg::*;
#(
  parameter int DATA_W      = WB_DATA_W,
  parameter int REG_AW      = WB_REG_AW,
  parameter int CNT_W       = 16,
  parameter bit ZERO_REG_RO = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_valid,
  input  logic              mem_reg_write,
  input  logic [REG_AW-1:0] mem_dst_reg,
  input  logic [1:0]        mem_wb_sel,
  input  logic [DATA_W-1:0] mem_alu_res,
  input  logic [DATA_W-1:0] mem_load_data,
  input  logic [DATA_W-1:0] mem_pc_plus2,
  input  logic              mem_halt,
  input  logic              wb_stall,
  input  logic              wb_flush,
  output logic [REG_AW-1:0] DstReg,
  output logic              WriteReg,
  output logic [DATA_W-1:0] DstData,
  output logic              fwd_valid,
  output logic              halted,
  output logic [CNT_W-1:0]  retired
);

  wb_bundle_t mem_bundle;
  wb_bundle_t wb_q;
  logic       load_valid;
  logic       dst_blocked;

  always_comb begin
    mem_bundle           = WB_BUBBLE;
    mem_bundle.valid     = mem_valid;
    mem_bundle.reg_write = mem_reg_write;
    mem_bundle.dst       = mem_dst_reg;
    mem_bundle.sel       = wb_sel_t'(mem_wb_sel);
    mem_bundle.alu       = mem_alu_res;
    mem_bundle.load      = mem_load_data;
    mem_bundle.pc2       = mem_pc_plus2;
    mem_bundle.halt      = mem_halt;
  end

  wb_pipe_reg u_pipe (
    .clk    (clk),
    .rst    (rst),
    .halted (halted),
    .flush  (wb_flush),
    .stall  (wb_stall),
    .d      (mem_bundle),
    .q      (wb_q)
  );

  // A real instruction actually enters WB this edge (drives both halted and retired).
  assign load_valid = mem_valid && !halted && !wb_flush && !wb_stall;

  assign dst_blocked = ZERO_REG_RO && (wb_q.dst == '0);
  assign DstReg      = wb_q.dst;
  assign DstData     = wb_q.valid ? wb_select(wb_q) : '0;
  assign WriteReg    = wb_q.valid && wb_q.reg_write && !wb_q.halt && !dst_blocked;
  assign fwd_valid   = WriteReg;

  always_ff @(posedge clk) begin
    if (rst) begin
      halted <= 1'b0;
    end else if (load_valid && mem_halt) begin
      halted <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      retired <= '0;
    end else if (load_valid && (retired != {CNT_W{1'b1}})) begin
      retired <= retired + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_regfile_writeback.sv
// Scoreboard bench for regfile_writeback: default, R0-writable and 4-bit-counter
// instances share stimulus and are checked against a plain behavioural model.
module tb_regfile_writeback;

  typedef struct packed {
    logic        rst;
    logic        valid;
    logic        rw;
    logic [3:0]  dst;
    logic [1:0]  sel;
    logic [15:0] alu;
    logic [15:0] load;
    logic [15:0] pc2;
    logic        halt;
    logic        stall;
    logic        flush;
  } stim_t;

  typedef struct {
    logic        chk_dst;
    logic [3:0]  dst;
    logic        wr;
    logic        wr_nz;
    logic [15:0] data;
    logic        halted;
    logic [15:0] ret;
    logic [3:0]  ret4;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst, mem_valid, mem_reg_write, mem_halt, wb_stall, wb_flush;
  logic [3:0]  mem_dst_reg;
  logic [1:0]  mem_wb_sel;
  logic [15:0] mem_alu_res, mem_load_data, mem_pc_plus2;

  logic [3:0]  a_dst, b_dst, c_dst;
  logic        a_wr, b_wr, c_wr, a_fwd, b_fwd, c_fwd, a_halt, b_halt, c_halt;
  logic [15:0] a_data, b_data, c_data, a_ret, b_ret;
  logic [3:0]  c_ret;

  int assertions = 0;
  int failures   = 0;
  exp_t exp_q[$];

  // Behavioural model of the WB contents and the architectural counters.
  logic        m_valid, m_rw, m_halt, m_halted;
  logic [3:0]  m_dst;
  logic [1:0]  m_sel;
  logic [15:0] m_alu, m_load, m_pc2;
  int          m_count;

  always #5 clk = ~clk;

  regfile_writeback dut (
    .clk(clk), .rst(rst), .mem_valid(mem_valid), .mem_reg_write(mem_reg_write),
    .mem_dst_reg(mem_dst_reg), .mem_wb_sel(mem_wb_sel), .mem_alu_res(mem_alu_res),
    .mem_load_data(mem_load_data), .mem_pc_plus2(mem_pc_plus2), .mem_halt(mem_halt),
    .wb_stall(wb_stall), .wb_flush(wb_flush), .DstReg(a_dst), .WriteReg(a_wr),
    .DstData(a_data), .fwd_valid(a_fwd), .halted(a_halt), .retired(a_ret)
  );

  regfile_writeback #(.ZERO_REG_RO(1'b0)) dut_nz (
    .clk(clk), .rst(rst), .mem_valid(mem_valid), .mem_reg_write(mem_reg_write),
    .mem_dst_reg(mem_dst_reg), .mem_wb_sel(mem_wb_sel), .mem_alu_res(mem_alu_res),
    .mem_load_data(mem_load_data), .mem_pc_plus2(mem_pc_plus2), .mem_halt(mem_halt),
    .wb_stall(wb_stall), .wb_flush(wb_flush), .DstReg(b_dst), .WriteReg(b_wr),
    .DstData(b_data), .fwd_valid(b_fwd), .halted(b_halt), .retired(b_ret)
  );

  regfile_writeback #(.CNT_W(4)) dut_c4 (
    .clk(clk), .rst(rst), .mem_valid(mem_valid), .mem_reg_write(mem_reg_write),
    .mem_dst_reg(mem_dst_reg), .mem_wb_sel(mem_wb_sel), .mem_alu_res(mem_alu_res),
    .mem_load_data(mem_load_data), .mem_pc_plus2(mem_pc_plus2), .mem_halt(mem_halt),
    .wb_stall(wb_stall), .wb_flush(wb_flush), .DstReg(c_dst), .WriteReg(c_wr),
    .DstData(c_data), .fwd_valid(c_fwd), .halted(c_halt), .retired(c_ret)
  );

  function automatic stim_t mkInstr(input logic [3:0] dst, input logic [1:0] sel,
                                    input logic [15:0] alu, input logic [15:0] load,
                                    input logic [15:0] pc2);
    stim_t s;
    s = '0;
    s.valid = 1'b1; s.rw = 1'b1; s.dst = dst; s.sel = sel;
    s.alu = alu; s.load = load; s.pc2 = pc2;
    return s;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    assertions++;
    if (act !== req) begin
      failures++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
    end
  endtask

  // Drive one cycle, advance the model across the same edge, queue the expectation.
  task automatic applyStimulus(input stim_t s);
    exp_t e;
    rst = s.rst; mem_valid = s.valid; mem_reg_write = s.rw; mem_dst_reg = s.dst;
    mem_wb_sel = s.sel; mem_alu_res = s.alu; mem_load_data = s.load;
    mem_pc_plus2 = s.pc2; mem_halt = s.halt; wb_stall = s.stall; wb_flush = s.flush;
    @(posedge clk);
    if (s.rst || m_halted || s.flush) begin
      {m_valid, m_rw, m_dst, m_sel, m_alu, m_load, m_pc2, m_halt} = '0;
      if (s.rst) begin
        m_halted = 1'b0;
        m_count  = 0;
      end
    end else if (!s.stall) begin
      {m_valid, m_rw, m_dst, m_sel, m_alu, m_load, m_pc2, m_halt} =
        {s.valid, s.rw, s.dst, s.sel, s.alu, s.load, s.pc2, s.halt};
      if (s.valid) begin
        m_count++;
        if (s.halt) m_halted = 1'b1;
      end
    end
    e.chk_dst = m_valid;
    e.dst     = m_dst;
    e.wr_nz   = m_valid && m_rw && !m_halt;
    e.wr      = e.wr_nz && (m_dst != 4'd0);
    e.data    = !m_valid ? 16'h0 : (m_sel == 2'd1) ? m_load : (m_sel == 2'd2) ? m_pc2 : m_alu;
    e.halted  = m_halted;
    e.ret     = (m_count > 65535) ? 16'hFFFF : 16'(m_count);
    e.ret4    = (m_count > 15) ? 4'hF : 4'(m_count);
    exp_q.push_back(e);
    #1;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        if (e.chk_dst) begin
          checkOutput("DstReg", 32'(a_dst), 32'(e.dst));
          checkOutput("DstReg_nz", 32'(b_dst), 32'(e.dst));
          checkOutput("DstReg_c4", 32'(c_dst), 32'(e.dst));
        end
        checkOutput("WriteReg", 32'(a_wr), 32'(e.wr));
        checkOutput("fwd_valid", 32'(a_fwd), 32'(e.wr));
        checkOutput("WriteReg_nz", 32'(b_wr), 32'(e.wr_nz));
        checkOutput("fwd_valid_nz", 32'(b_fwd), 32'(e.wr_nz));
        checkOutput("WriteReg_c4", 32'(c_wr), 32'(e.wr));
        checkOutput("fwd_valid_c4", 32'(c_fwd), 32'(e.wr));
        checkOutput("DstData", 32'(a_data), 32'(e.data));
        checkOutput("DstData_nz", 32'(b_data), 32'(e.data));
        checkOutput("DstData_c4", 32'(c_data), 32'(e.data));
        checkOutput("halted", 32'(a_halt), 32'(e.halted));
        checkOutput("halted_nz", 32'(b_halt), 32'(e.halted));
        checkOutput("halted_c4", 32'(c_halt), 32'(e.halted));
        checkOutput("retired", 32'(a_ret), 32'(e.ret));
        checkOutput("retired_nz", 32'(b_ret), 32'(e.ret));
        checkOutput("retired_c4", 32'(c_ret), 32'(e.ret4));
      end
    end
  end

  initial begin : stimulus
    stim_t s;
    stim_t idle;
    idle = '0;
    m_halted = 1'b0;
    m_count  = 0;
    {m_valid, m_rw, m_dst, m_sel, m_alu, m_load, m_pc2, m_halt} = '0;

    s = idle; s.rst = 1'b1;
    applyStimulus(s);
    applyStimulus(s);

    // ALU write, the select variants and the R0 guard.
    applyStimulus(mkInstr(4'd3, 2'b00, 16'h1234, 16'h0, 16'h0));
    applyStimulus(mkInstr(4'd4, 2'b01, 16'h1111, 16'hBEEF, 16'h2222));
    applyStimulus(mkInstr(4'd6, 2'b10, 16'h3333, 16'h4444, 16'h0042));
    applyStimulus(mkInstr(4'd9, 2'b11, 16'h5555, 16'h6666, 16'h7777));
    applyStimulus(mkInstr(4'd0, 2'b00, 16'hA5A5, 16'h0, 16'h0));
    applyStimulus(idle);

    // Three-cycle stall with fresh MEM contents, then stall and flush together.
    applyStimulus(mkInstr(4'd7, 2'b00, 16'hAAAA, 16'h0, 16'h0));
    for (int i = 0; i < 3; i++) begin
      s = mkInstr(4'd8, 2'b01, 16'h0BAD, 16'hF00D, 16'h0);
      s.stall = 1'b1;
      applyStimulus(s);
    end
    s.flush = 1'b1;
    applyStimulus(s);

    // HLT followed by writes that must never land, then reset clears everything.
    s = mkInstr(4'd2, 2'b00, 16'h9999, 16'h0, 16'h0);
    s.halt = 1'b1;
    applyStimulus(s);
    for (int i = 0; i < 4; i++) applyStimulus(mkInstr(4'd5, 2'b00, 16'h0055, 16'h0, 16'h0));
    s = idle; s.rst = 1'b1;
    applyStimulus(s);

    // Twenty back-to-back instructions saturate the narrow counter.
    for (int i = 0; i < 20; i++)
      applyStimulus(mkInstr(4'(i + 1), 2'b00, 16'(i * 3), 16'h0, 16'h0));

    for (int i = 0; i < 400; i++) begin
      s.rst   = ($urandom_range(0, 49) == 0);
      s.valid = ($urandom_range(0, 3) != 0);
      s.rw    = ($urandom_range(0, 9) < 7);
      s.dst   = 4'($urandom_range(0, 15));
      s.sel   = 2'($urandom_range(0, 3));
      s.alu   = 16'($urandom);
      s.load  = 16'($urandom);
      s.pc2   = 16'($urandom);
      s.halt  = ($urandom_range(0, 39) == 0);
      s.stall = ($urandom_range(0, 4) == 0);
      s.flush = ($urandom_range(0, 9) == 0);
      applyStimulus(s);
    end

    applyStimulus(idle);
    for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(negedge clk);
    #1;
    checkOutput("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

endmodule
